// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: states, opcodes,
// ALU operations and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU       = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_ALU_ALIGN = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Decides when a memory access finishes: either after MEM_LATENCY cycles in
// the access state, or on the first cycle mem_ready is seen.
module mem_wait_counter #(
  parameter int MEM_LATENCY   = 1,
  parameter bit USE_MEM_READY = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    if (USE_MEM_READY) begin
      done_o = active_i & mem_ready_i;
    end else begin
      done_o = active_i & (cnt_q == 4'(MEM_LATENCY - 1));
    end
  end

  // Every exit from an access state happens on done, so clearing here also
  // guarantees a zero count on the next state entry.
  always_comb begin
    cnt_d = cnt_q + 4'd1;
    if (!active_i || done_o) begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 subset control FSM: FETCH/DECODE/EXEC/MEM/WB plus a sticky
// TRAP for unsupported opcodes. Outputs are decoded from the current state.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY   = 1,
  parameter bit USE_MEM_READY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_instr,
  output logic [2:0] state_o
);

  state_e     state_q, state_d;
  logic [6:0] opcode_q;
  logic       illegal_q;
  logic       mem_done;
  ctrl_t      ctrl;
  logic       unused_funct3;

  assign unused_funct3 = ^funct3[2:1];

  mem_wait_counter #(
    .MEM_LATENCY  (MEM_LATENCY),
    .USE_MEM_READY(USE_MEM_READY)
  ) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .active_i   ((state_q == ST_FETCH) || (state_q == ST_MEM)),
    .mem_ready_i(mem_ready),
    .done_o     (mem_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_done) state_d = ST_DECODE;
      ST_DECODE: state_d = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (opcode_q)
          OP_LOAD, OP_STORE:         state_d = ST_MEM;
          OP_RTYPE, OP_IALU, OP_LUI: state_d = ST_WB;
          default:                   state_d = ST_FETCH;
        endcase
      end
      ST_MEM:    if (mem_done) state_d = (opcode_q == OP_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 7'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode;
      end
      if (state_d == ST_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Gating with rst_n makes every enable drop the instant reset asserts,
  // even though FETCH (the reset state) would otherwise drive mem_read.
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_a = SRC_A_PC;
          ctrl.alu_src_b = SRC_B_FOUR;
          ctrl.alu_op    = ALU_ADD;
          if (mem_done) begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_ALU;
          end
        end
        ST_DECODE: begin
          ctrl.alu_src_a = SRC_A_OLD_PC;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        ST_EXEC: begin
          case (opcode_q)
            OP_RTYPE: begin
              ctrl.alu_src_a = SRC_A_RS1;
              ctrl.alu_src_b = SRC_B_RS2;
              ctrl.alu_op    = ALU_FUNCT;
            end
            OP_IALU: begin
              ctrl.alu_src_a = SRC_A_RS1;
              ctrl.alu_src_b = SRC_B_IMM;
              ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LUI: begin
              ctrl.alu_src_b = SRC_B_IMM;
              ctrl.alu_op    = ALU_PASS_B;
            end
            OP_LOAD, OP_STORE: begin
              ctrl.alu_src_a = SRC_A_RS1;
              ctrl.alu_src_b = SRC_B_IMM;
              ctrl.alu_op    = ALU_ADD;
            end
            OP_BRANCH: begin
              ctrl.alu_src_a     = SRC_A_RS1;
              ctrl.alu_src_b     = SRC_B_RS2;
              ctrl.alu_op        = ALU_SUB;
              ctrl.pc_write_cond = 1'b1;
              ctrl.pc_source     = PCSRC_ALUOUT;
              ctrl.branch_ne     = funct3[0];
            end
            OP_JAL: begin
              ctrl.pc_write   = 1'b1;
              ctrl.pc_source  = PCSRC_ALUOUT;
              ctrl.reg_write  = 1'b1;
              ctrl.mem_to_reg = M2R_PC;
            end
            OP_JALR: begin
              ctrl.alu_src_a  = SRC_A_RS1;
              ctrl.alu_src_b  = SRC_B_IMM;
              ctrl.alu_op     = ALU_ADD;
              ctrl.pc_write   = 1'b1;
              ctrl.pc_source  = PCSRC_ALU_ALIGN;
              ctrl.reg_write  = 1'b1;
              ctrl.mem_to_reg = M2R_PC;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          ctrl.i_or_d    = 1'b1;
          ctrl.mem_read  = (opcode_q == OP_LOAD);
          ctrl.mem_write = (opcode_q == OP_STORE);
        end
        ST_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = (opcode_q == OP_LOAD) ? M2R_MDR : M2R_ALUOUT;
        end
        default: ;
      endcase
    end
  end

  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_instr = illegal_q;
  assign state_o       = state_q;

endmodule
